// File: rtl/gf2_poly_pkg.sv
// Shared widths and state encoding for the GF(2)[x] sequential divider.
package gf2_poly_pkg;

    localparam int N  = 33;
    localparam int DW = 2 * N - 1;
    localparam int RW = N - 1;
    localparam int CW = $clog2(DW);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gf2_msb_index.sv
// Priority encoder: index of the highest set bit, plus an all-zero flag.
module gf2_msb_index #(
    parameter int W  = 33,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx  = IW'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gf2_poly_divider_seq.sv
// Bit-serial GF(2)[x] long divider: one dividend coefficient per clock,
// quotient and remainder registered on completion.
module gf2_poly_divider_seq
    import gf2_poly_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [N-1:0]  divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [RW-1:0] remainder,
    output logic          div_by_zero
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] r_q, r_d;
    logic [DW-2:0] q_q, q_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [RW-1:0] dvs_q, dvs_d;
    logic [IW-1:0] msb_q, msb_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [IW-1:0] msb_idx;
    logic          dvs_zero;
    logic [N-1:0]  t;
    logic          qbit;
    logic [RW-1:0] t_red;

    gf2_msb_index #(.W(N), .IW(IW)) u_msb (
        .vec  (divisor),
        .idx  (msb_idx),
        .zero (dvs_zero)
    );

    // The divisor MSB is implied by msb_q; only its lower RW bits are kept,
    // since the top bit of t is always cancelled and then dropped.
    always_comb begin
        t     = {r_q, dvd_q[DW-1]};
        qbit  = t[msb_q];
        t_red = t[RW-1:0] ^ (qbit ? dvs_q : '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        msb_d     = msb_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dvd_d = dividend;
                    dvs_d = divisor[RW-1:0];
                    msb_d = msb_idx;
                    r_d   = '0;
                    q_d   = '0;
                    cnt_d = CW'(DW - 1);
                    if (dvs_zero) begin
                        quo_d   = '0;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                r_d   = t_red;
                q_d   = {q_q[DW-3:0], qbit};
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                if (cnt_q == '0) begin
                    quo_d   = {q_q, qbit};
                    rem_d   = t_red;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            msb_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            msb_q   <= msb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf2_poly_divider_seq.sv
// Directed and randomized checks of the GF(2)[x] divider against a
// polynomial long-division reference model.
module tb_gf2_poly_divider_seq;
    import gf2_poly_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [N-1:0]  divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [RW-1:0] remainder;
    logic          div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    gf2_poly_divider_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int deg(input logic [DW-1:0] p);
        for (int i = DW - 1; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    // Textbook long division: cancel the leading term until deg(r) < deg(b).
    task automatic ref_div(input logic [DW-1:0] a, input logic [N-1:0] b,
                           output logic [DW-1:0] q, output logic [RW-1:0] r);
        logic [DW-1:0] rr;
        logic [DW-1:0] bb;
        int db;
        int sh;
        rr = a;
        bb = DW'(b);
        db = deg(bb);
        q  = '0;
        r  = '0;
        if (db >= 0) begin
            while (deg(rr) >= db) begin
                sh = deg(rr) - db;
                q[sh] = 1'b1;
                rr = rr ^ (bb << sh);
            end
            r = rr[RW-1:0];
        end
    endtask

    function automatic logic [DW-1:0] clmul(input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [DW-1:0] y;
        y = '0;
        for (int i = 0; i < N; i++) if (b[i]) y = y ^ (DW'(a) << i);
        return y;
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[N-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_dw();
        logic [95:0] v;
        v = {$urandom, $urandom, $urandom};
        return v[DW-1:0];
    endfunction

    task automatic do_op(input logic [DW-1:0] a, input logic [N-1:0] b,
                         output logic [DW-1:0] q, output logic [RW-1:0] r,
                         output logic z, output int lat);
        int n;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_vec(input string tag, input logic [DW-1:0] a,
                             input logic [N-1:0] b);
        logic [DW-1:0] q, eq;
        logic [RW-1:0] r, er;
        logic z;
        int lat;
        ref_div(a, b, eq, er);
        do_op(a, b, q, r, z, lat);
        chk({tag, "_lat"}, DW'(lat), DW'((b == '0) ? 0 : DW));
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, DW'(r), DW'(er));
        chk({tag, "_dbz"}, DW'(z), DW'(b == '0));
        release_out();
    endtask

    initial begin
        logic [DW-1:0] q, y, hold_q;
        logic [RW-1:0] r;
        logic [N-1:0]  a, b;
        logic z;
        int lat;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_q", quotient, '0);
        chk("rst_r", DW'(remainder), '0);
        chk("rst_dbz", DW'(div_by_zero), '0);

        do_op(DW'(5), N'(3), q, r, z, lat);
        chk("t1_lat", DW'(lat), DW'(65));
        chk("t1_q", q, DW'(3));
        chk("t1_r", DW'(r), '0);
        chk("t1_dbz", DW'(z), '0);
        release_out();
        chk("t1_idle", DW'(in_ready), DW'(1));

        do_op(DW'(7), N'(3), q, r, z, lat);
        chk("t2_q", q, DW'(2));
        chk("t2_r", DW'(r), DW'(1));
        release_out();

        do_op(rand_dw(), '0, q, r, z, lat);
        chk("t3_lat", DW'(lat), '0);
        chk("t3_dbz", DW'(z), DW'(1));
        chk("t3_q", q, '0);
        chk("t3_r", DW'(r), '0);
        release_out();

        do_op('1, N'(1), q, r, z, lat);
        chk("t4_q", q, '1);
        chk("t4_r", DW'(r), '0);
        release_out();

        b = rand_n();
        b[N-1] = 1'b1;
        y = rand_dw();
        check_vec("deg_top", y, b);
        ref_div(y, b, q, r);
        chk("deg_top_qhi", q >> N, '0);

        for (int i = 0; i < 60; i++) begin
            b = rand_n() >> $urandom_range(0, N);
            check_vec("rnd", rand_dw(), b);
        end

        for (int i = 0; i < 1000; i++) begin
            a = rand_n();
            b = rand_n() >> $urandom_range(0, N - 1);
            if (b == '0) b = N'(1);
            y = clmul(a, b);
            do_op(y, b, q, r, z, lat);
            chk("rt_lat", DW'(lat), DW'(65));
            chk("rt_q", q, DW'(a));
            chk("rt_r", DW'(r), '0);
            release_out();
        end

        a = rand_n();
        b = rand_n() | N'(1);
        y = clmul(a, b);
        do_op(y, b, q, r, z, lat);
        hold_q = q;
        dividend = rand_dw();
        divisor = N'(1);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", DW'(out_valid), DW'(1));
            chk("hold_ready", DW'(in_ready), '0);
            chk("hold_q", quotient, hold_q);
        end
        in_valid = 1'b0;
        chk("hold_result", hold_q, DW'(a));
        release_out();

        dividend = rand_dw();
        divisor  = rand_n() | N'(1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", DW'(in_ready), DW'(1));
        chk("abort_out_valid", DW'(out_valid), '0);
        chk("abort_q", quotient, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle", DW'(out_valid), '0);
        check_vec("restart", rand_dw(), rand_n() | N'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
